// File: rtl/timer_clock_controller.sv
// 60-minute BCD timer sequencer: prescaled 1 Hz stepping, run/pause/clear FSM, 59:59 wrap, minute-limit expiry.
// Optional lap capture is enabled with `define TIMER_CLOCK_CTRL_LAP_EN.
module timer_clock_controller #(
  parameter int TICK_DIV = 50000000,
  parameter int PRE_W    = 26
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Clear,
  input  logic [7:0] LimitMin,
  output logic [7:0] SecOut,
  output logic [7:0] MinOut,
  output logic       SecTick,
  output logic       Running,
  output logic       Done,
`ifdef TIMER_CLOCK_CTRL_LAP_EN
  input  logic       Lap,
  output logic [7:0] LapSec,
  output logic [7:0] LapMin,
  output logic       LapValid,
`endif
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [7:0]       sec_q, sec_d;
  logic [7:0]       min_q, min_d;
  logic [7:0]       limit_q, limit_d;
  logic             tick_q, tick_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic [8:0]       sec_inc;
  logic [8:0]       min_inc;
  logic             limit_ok;

  // Returns {carry, next} for a two-digit 00..59 BCD count.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] != 4'd9)      return {1'b0, v[7:4], v[3:0] + 4'd1};
    else if (v[7:4] != 4'd5) return {1'b0, v[7:4] + 4'd1, 4'd0};
    else                     return 9'h100;
  endfunction

  assign sec_inc  = bcd_inc(sec_q);
  assign min_inc  = bcd_inc(min_q);
  assign limit_ok = (LimitMin[7:4] <= 4'd5) && (LimitMin[3:0] <= 4'd9);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    sec_d   = sec_q;
    min_d   = min_q;
    limit_d = limit_q;
    tick_d  = 1'b0;
    if (Clear) begin
      state_d = ST_IDLE;
      pre_d   = '0;
      sec_d   = 8'h00;
      min_d   = 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: if (!Stop && Start) begin
          state_d = ST_RUNNING;
          pre_d   = '0;
          limit_d = limit_ok ? LimitMin : 8'h00;
        end
        ST_RUNNING: begin
          // Stop beats a coincident step: prescaler parks at PRE_LAST so resume steps at once.
          if (Stop) begin
            state_d = ST_PAUSED;
          end else if (pre_q == PRE_LAST) begin
            pre_d  = '0;
            tick_d = 1'b1;
            sec_d  = sec_inc[7:0];
            if (sec_inc[8]) min_d = min_inc[7:0];
            if (sec_inc[8] && (limit_q != 8'h00) && (min_inc[7:0] == limit_q))
              state_d = ST_EXPIRED;
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
        ST_PAUSED: if (!Stop && Start) state_d = ST_RUNNING;
        default: ;
      endcase
    end
    running_d = (state_d == ST_RUNNING);
    done_d    = (state_d == ST_EXPIRED);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      pre_q     <= '0;
      sec_q     <= 8'h00;
      min_q     <= 8'h00;
      limit_q   <= 8'h00;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      limit_q   <= limit_d;
      tick_q    <= tick_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign SecOut    = sec_q;
  assign MinOut    = min_q;
  assign SecTick   = tick_q;
  assign Running   = running_q;
  assign Done      = done_q;
  assign state_dbg = state_q;

`ifdef TIMER_CLOCK_CTRL_LAP_EN
  logic       lap_prev_q, lap_prev_d;
  logic [7:0] lap_sec_q, lap_sec_d;
  logic [7:0] lap_min_q, lap_min_d;
  logic       lap_valid_q, lap_valid_d;

  // Captures the pre-step count, since sec_q/min_q have not yet taken a coincident step.
  always_comb begin
    lap_prev_d  = Lap;
    lap_sec_d   = lap_sec_q;
    lap_min_d   = lap_min_q;
    lap_valid_d = lap_valid_q;
    if (Clear) begin
      lap_sec_d   = 8'h00;
      lap_min_d   = 8'h00;
      lap_valid_d = 1'b0;
    end else if (Lap && !lap_prev_q &&
                 (state_q == ST_RUNNING || state_q == ST_PAUSED)) begin
      lap_sec_d   = sec_q;
      lap_min_d   = min_q;
      lap_valid_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      lap_prev_q  <= 1'b0;
      lap_sec_q   <= 8'h00;
      lap_min_q   <= 8'h00;
      lap_valid_q <= 1'b0;
    end else begin
      lap_prev_q  <= lap_prev_d;
      lap_sec_q   <= lap_sec_d;
      lap_min_q   <= lap_min_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  assign LapSec   = lap_sec_q;
  assign LapMin   = lap_min_q;
  assign LapValid = lap_valid_q;
`endif

endmodule

// File: tb/tb_timer_clock_controller.sv
// Directed bench for timer_clock_controller with TICK_DIV=4: stepping, wrap, limit expiry, stop/clear priority, reset.
module tb_timer_clock_controller;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUNNING = 2'd1;
  localparam logic [1:0] S_PAUSED  = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  logic       Clk;
  logic       Rst;
  logic       Start;
  logic       Stop;
  logic       Clear;
  logic [7:0] LimitMin;
  logic [7:0] SecOut;
  logic [7:0] MinOut;
  logic       SecTick;
  logic       Running;
  logic       Done;
  logic [1:0] state_dbg;
`ifdef TIMER_CLOCK_CTRL_LAP_EN
  logic       Lap;
  logic [7:0] LapSec;
  logic [7:0] LapMin;
  logic       LapValid;
`endif

  int checks = 0;
  int errors = 0;

  timer_clock_controller #(.TICK_DIV(4), .PRE_W(3)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (Start),
    .Stop     (Stop),
    .Clear    (Clear),
    .LimitMin (LimitMin),
    .SecOut   (SecOut),
    .MinOut   (MinOut),
    .SecTick  (SecTick),
    .Running  (Running),
    .Done     (Done),
`ifdef TIMER_CLOCK_CTRL_LAP_EN
    .Lap      (Lap),
    .LapSec   (LapSec),
    .LapMin   (LapMin),
    .LapValid (LapValid),
`endif
    .state_dbg(state_dbg)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    clk_n(1);
    Start = 1'b0;
  endtask

  task automatic pulse_clear();
    Clear = 1'b1;
    clk_n(1);
    Clear = 1'b0;
  endtask

  // Each step must arrive within a bounded number of cycles.
  task automatic run_steps(input int n);
    for (int s = 0; s < n; s++) begin
      int k;
      k = 0;
      while (k < 8) begin
        clk_n(1);
        k++;
        if (SecTick === 1'b1) break;
      end
      checks++;
      assert (SecTick === 1'b1) else begin
        errors++;
        $error("FAIL step_timeout: observed SecTick=%b expected 1 at step %0d", SecTick, s);
        return;
      end
    end
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; Stop = 1'b0; Clear = 1'b0; LimitMin = 8'h00;
`ifdef TIMER_CLOCK_CTRL_LAP_EN
    Lap = 1'b0;
`endif
    clk_n(2);
    chk("rst_sec", SecOut, 8'h00);
    chk("rst_min", MinOut, 8'h00);
    chk("rst_tick", {7'd0, SecTick}, 8'h00);
    chk("rst_running", {7'd0, Running}, 8'h00);
    chk("rst_done", {7'd0, Done}, 8'h00);
    chk("rst_state", {6'd0, state_dbg}, {6'd0, S_IDLE});
    Rst = 1'b0;
    clk_n(2);

    // First step lands four cycles after entering RUNNING
    pulse_start();
    chk("start_running", {7'd0, Running}, 8'h01);
    chk("start_state", {6'd0, state_dbg}, {6'd0, S_RUNNING});
    clk_n(3);
    chk("pre_tick_low", {7'd0, SecTick}, 8'h00);
    chk("pre_sec", SecOut, 8'h00);
    clk_n(1);
    chk("first_tick", {7'd0, SecTick}, 8'h01);
    chk("first_sec", SecOut, 8'h01);
    clk_n(1);
    chk("tick_one_cycle", {7'd0, SecTick}, 8'h00);
    run_steps(9);
    chk("sec_10", SecOut, 8'h10);
    chk("min_after_10", MinOut, 8'h00);
    run_steps(50);
    chk("sec_60", SecOut, 8'h00);
    chk("min_60", MinOut, 8'h01);

    // Asynchronous reset mid-run
    pulse_clear();
    chk("clear_sec", SecOut, 8'h00);
    chk("clear_min", MinOut, 8'h00);
    chk("clear_state", {6'd0, state_dbg}, {6'd0, S_IDLE});
    pulse_start();
    run_steps(3);
    chk("pre_rst_sec", SecOut, 8'h03);
    #2 Rst = 1'b1;
    #1;
    chk("async_rst_sec", SecOut, 8'h00);
    chk("async_rst_running", {7'd0, Running}, 8'h00);
    chk("async_rst_tick", {7'd0, SecTick}, 8'h00);
    clk_n(1);
    Rst = 1'b0;
    clk_n(2);
    chk("post_rst_state", {6'd0, state_dbg}, {6'd0, S_IDLE});
    chk("post_rst_sec", SecOut, 8'h00);
    pulse_start();
    run_steps(1);
    chk("post_rst_count_sec", SecOut, 8'h01);
    chk("post_rst_count_min", MinOut, 8'h00);

    // Stop coincident with the step out of 00:05
    pulse_clear();
    pulse_start();
    run_steps(5);
    chk("stop_pre_sec", SecOut, 8'h05);
    clk_n(3);
    Stop = 1'b1;
    clk_n(1);
    Stop = 1'b0;
    chk("stop_sec_held", SecOut, 8'h05);
    chk("stop_tick", {7'd0, SecTick}, 8'h00);
    chk("stop_running", {7'd0, Running}, 8'h00);
    chk("stop_state", {6'd0, state_dbg}, {6'd0, S_PAUSED});
    clk_n(5);
    chk("paused_sec", SecOut, 8'h05);
    pulse_start();
    chk("resume_running", {7'd0, Running}, 8'h01);
    chk("resume_tick_low", {7'd0, SecTick}, 8'h00);
    clk_n(1);
    chk("resume_tick", {7'd0, SecTick}, 8'h01);
    chk("resume_sec", SecOut, 8'h06);

    // All three commands at once: Clear wins
    run_steps(1);
    chk("all_pre_sec", SecOut, 8'h07);
    Start = 1'b1; Stop = 1'b1; Clear = 1'b1;
    clk_n(1);
    Start = 1'b0; Stop = 1'b0; Clear = 1'b0;
    chk("all_sec", SecOut, 8'h00);
    chk("all_min", MinOut, 8'h00);
    chk("all_running", {7'd0, Running}, 8'h00);
    chk("all_state", {6'd0, state_dbg}, {6'd0, S_IDLE});

    // Limit 02: latched at Start, later LimitMin changes must not matter
    LimitMin = 8'h02;
    pulse_start();
    LimitMin = 8'h01;
    run_steps(119);
    chk("lim_pre_min", MinOut, 8'h01);
    chk("lim_pre_sec", SecOut, 8'h59);
    chk("lim_pre_done", {7'd0, Done}, 8'h00);
    run_steps(1);
    chk("lim_min", MinOut, 8'h02);
    chk("lim_sec", SecOut, 8'h00);
    chk("lim_done", {7'd0, Done}, 8'h01);
    chk("lim_running", {7'd0, Running}, 8'h00);
    chk("lim_state", {6'd0, state_dbg}, {6'd0, S_EXPIRED});
    Start = 1'b1;
    clk_n(2);
    Start = 1'b0;
    clk_n(8);
    chk("exp_start_state", {6'd0, state_dbg}, {6'd0, S_EXPIRED});
    chk("exp_frozen_sec", SecOut, 8'h00);
    chk("exp_frozen_min", MinOut, 8'h02);
    chk("exp_tick", {7'd0, SecTick}, 8'h00);
    Stop = 1'b1;
    clk_n(1);
    Stop = 1'b0;
    chk("exp_stop_state", {6'd0, state_dbg}, {6'd0, S_EXPIRED});
    pulse_clear();
    chk("exp_clear_sec", SecOut, 8'h00);
    chk("exp_clear_min", MinOut, 8'h00);
    chk("exp_clear_done", {7'd0, Done}, 8'h00);
    chk("exp_clear_state", {6'd0, state_dbg}, {6'd0, S_IDLE});

    // Invalid limit free-runs through 59:59
    LimitMin = 8'h7A;
    pulse_start();
    LimitMin = 8'h00;
    run_steps(3599);
    chk("full_sec", SecOut, 8'h59);
    chk("full_min", MinOut, 8'h59);
    chk("full_done", {7'd0, Done}, 8'h00);
    run_steps(1);
    chk("wrap_sec", SecOut, 8'h00);
    chk("wrap_min", MinOut, 8'h00);
    chk("wrap_done", {7'd0, Done}, 8'h00);
    chk("wrap_running", {7'd0, Running}, 8'h01);
    run_steps(1);
    chk("post_wrap_sec", SecOut, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_clock_controller.md
Name: timer_clock_controller

Overview:
- Sequencing controller for the 60-minute decimal timer clock: derives a 1 Hz advance from the system clock and drives the seconds and minutes two-digit BCD counting.
- Owns the run/pause/clear state machine, the 59:59 wrap, and an optional minute-limit expiry.
- Sits between the board push-button/debounce logic and the display decoder.
- Outputs are packed BCD in {tens, ones} nibble order, matching the existing two-digit counter format.

Parameters:
- TICK_DIV, 50000000: Clk cycles per counting step (1 s at 50 MHz). Must be >= 2.
- PRE_W, 26: prescaler width. Must satisfy 2^PRE_W >= TICK_DIV.

Ports:
- Clk  in  1  system clock; all state changes on its rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Start  in  1  level; sampled every Clk; begin or resume counting.
- Stop  in  1  level; pause counting.
- Clear  in  1  level; return to 00:00 idle.
- LimitMin  in  8  BCD minute limit; 0x00 means no limit.
- SecOut  out  8  BCD seconds, 0x00..0x59.
- MinOut  out  8  BCD minutes, 0x00..0x59.
- SecTick  out  1  one-cycle pulse on each counting step.
- Running  out  1  high while in RUNNING.
- Done  out  1  high while in EXPIRED.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; SecOut, MinOut = 0x00; prescaler 0; SecTick, Running, Done = 0; latched limit 0x00.
- All outputs are registered.
- States: IDLE, RUNNING, PAUSED, EXPIRED.
- Command priority within a cycle: Clear > Stop > Start.
- Clear, from any state: next cycle IDLE, counters 00:00, prescaler 0, SecTick 0.
- IDLE + Start: go to RUNNING, prescaler 0. LimitMin is latched in this same cycle.
- Latched limit validity: if either nibble > 9, or the value > 0x59, it is latched as 0x00 (no limit).
- RUNNING + Stop: go to PAUSED. Prescaler and counters hold their values.
- PAUSED + Start: go to RUNNING. Prescaler resumes from its held value; the limit is NOT re-latched.
- EXPIRED: Start and Stop are ignored; only Clear or Rst exit.
- Start held high in RUNNING: no effect. Stop in IDLE, PAUSED or EXPIRED: no effect.
- Prescaler (RUNNING only): counts 0..TICK_DIV-1.
  - At TICK_DIV-1 it wraps to 0 and a step occurs.
  - First step therefore lands TICK_DIV cycles after the Start edge enters RUNNING.
- Step: SecTick = 1 for exactly that cycle, with SecOut/MinOut updated on the same edge.
  - Seconds ones digit 0..9 then wraps; a wrap carries into the tens digit.
  - Seconds tens digit 0..5; 0x59 -> 0x00 carries into minutes.
  - Minutes use identical BCD rules; 59:59 -> 00:00 wrap.
  - Non-BCD values never appear on the outputs.
- Expiry: when a step produces MinOut == latched limit, SecOut == 0x00, and the limit != 0x00, the FSM enters EXPIRED on that same edge.
  - Counters freeze at LIMIT:00 and Done = 1.
  - With limit 0x00 the timer free-runs and wraps forever.
- Stop and a step in the same cycle: Stop wins. No step is taken and the prescaler holds at TICK_DIV-1, so the step fires 1 cycle after resume.
- Clear and a step in the same cycle: Clear wins; outputs read 00:00 and SecTick stays 0.
- Rst mid-count: all state is lost immediately; no partial step occurs.

Optional Feature:
- Macro: TIMER_CLOCK_CTRL_LAP_EN.
- Defined:
  - Adds input Lap (1) and outputs LapSec (8), LapMin (8), LapValid (1).
  - A Lap rising edge (edge-detected internally) while RUNNING or PAUSED captures the current SecOut/MinOut.
  - LapSec/LapMin update and LapValid is set 1 cycle after the edge.
  - Clear or Rst zeroes LapSec/LapMin and clears LapValid.
  - If Lap coincides with a step, the captured value is the pre-step value.
- Undefined: none of these ports or registers exist; behaviour is otherwise identical.

Test Plan (TICK_DIV=4):
- Rst pulse mid-run at 00:03 -> outputs immediately 00:00, Running=0; a later Start counts from 00:00.
- LimitMin=0x00, Start for one cycle -> first SecTick 4 cycles later with SecOut=0x01; SecOut after 10 steps =0x10; after 60 steps SecOut=0x00 and MinOut=0x01.
- Free run to 59:59 plus one step -> SecOut=0x00, MinOut=0x00, Done=0, Running=1.
- LimitMin=0x02, Start -> after 120 steps state EXPIRED, MinOut=0x02, SecOut=0x00, Done=1; Start ignored; Clear -> 00:00, Done=0.
- Stop asserted in the same cycle as a step at 00:05 -> SecOut stays 0x05, Running=0; Start -> SecOut=0x06 one cycle after resume.
- Start, Stop and Clear all asserted together while RUNNING at 00:07 -> IDLE, 00:00. LimitMin=0x7A at Start -> no expiry at 59:59, wrap to 00:00.
